// File: rtl/prime_scan_ctrl_pkg.sv
// prime_scan_ctrl_pkg: shared state encoding and widths for the prime scan controller
package prime_scan_ctrl_pkg;
  localparam int VAL_W = 4;
  localparam int CNT_W_DEFAULT = 5;
  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
endpackage

// File: rtl/prime_div3_cls.sv
// prime_div3_cls: combinational prime / nonzero-multiple-of-3 classifier for a 4-bit value
module prime_div3_cls
  import prime_scan_ctrl_pkg::*;
(
  input  logic [VAL_W-1:0] value,
  output logic             p,
  output logic             d
);
  // one bit per value: primes 2,3,5,7,11,13 and multiples 3,6,9,12,15
  localparam logic [15:0] P_MASK = 16'h28AC;
  localparam logic [15:0] D_MASK = 16'h9248;
  assign p = P_MASK[value];
  assign d = D_MASK[value];
endmodule

// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl: walks lo..hi one value per accepted beat, classifying and counting
module prime_scan_ctrl
  import prime_scan_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] lo,
  input  logic [VAL_W-1:0] hi,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VAL_W-1:0] out_value,
  output logic             out_p,
  output logic             out_d,
  output logic [CNT_W-1:0] prime_cnt,
  output logic [CNT_W-1:0] div3_cnt,
  output logic             done,
  output logic             err
);
  state_t           state_q, state_d;
  logic [VAL_W-1:0] cur_q, cur_d, hi_q, hi_d;
  logic [CNT_W-1:0] prime_cnt_q, prime_cnt_d, div3_cnt_q, div3_cnt_d;
  logic             err_q, err_d, cls_p, cls_d;

  prime_div3_cls u_cls (.value(cur_q), .p(cls_p), .d(cls_d));

  // state, cursor, captured bound, counters and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      hi_q        <= '0;
      prime_cnt_q <= '0;
      div3_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      hi_q        <= hi_d;
      prime_cnt_q <= prime_cnt_d;
      div3_cnt_q  <= div3_cnt_d;
      err_q       <= err_d;
    end
  end

  // next state: end of scan is detected by cur==hi so hi=15 never needs cur to wrap
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    hi_d        = hi_q;
    prime_cnt_d = prime_cnt_q;
    div3_cnt_d  = div3_cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: if (start) begin
        prime_cnt_d = '0;
        div3_cnt_d  = '0;
        err_d       = lo > hi;
        state_d     = lo > hi ? FIN : SCAN;
        if (lo <= hi) begin
          cur_d = lo;
          hi_d  = hi;
        end
      end
      SCAN: if (out_ready) begin
        prime_cnt_d = prime_cnt_q + CNT_W'(cls_p);
        div3_cnt_d  = div3_cnt_q + CNT_W'(cls_d);
        state_d     = cur_q == hi_q ? FIN : SCAN;
        cur_d       = cur_q == hi_q ? cur_q : cur_q + VAL_W'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = state_q == SCAN;
  assign out_valid = busy;
  assign out_value = cur_q;
  assign out_p     = cls_p;
  assign out_d     = cls_d;
  assign done      = state_q == FIN;
  assign prime_cnt = prime_cnt_q;
  assign div3_cnt  = div3_cnt_q;
  assign err       = err_q;
endmodule
